// File: rtl/assert_event_logger.sv
// rtl/assert_event_logger.sv - gated pass/fail counters with a timestamped failure-record FIFO
module assert_event_logger #(
    parameter int NUM_CHK    = 4,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int ID_W      = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CHK-1:0]       chk_valid,
    input  logic [NUM_CHK-1:0]       chk_pass,
    input  logic                     global_en,
    input  logic [NUM_CHK-1:0]       chk_mask,
    input  logic                     gate_rst,
    input  logic                     clr_cnt,
    output logic [NUM_CHK*CNT_W-1:0] pass_cnt,
    output logic [NUM_CHK*CNT_W-1:0] fail_cnt,
    output logic                     any_fail,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [ID_W-1:0]          rec_id,
    output logic [TS_W-1:0]          rec_ts,
    output logic                     overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] pass_q [NUM_CHK];
    logic [CNT_W-1:0] fail_q [NUM_CHK];
    logic [NUM_CHK-1:0] pend;
    logic [TS_W-1:0]  pend_ts [NUM_CHK];

    logic [ID_W-1:0]  mem_id [FIFO_DEPTH];
    logic [TS_W-1:0]  mem_ts [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;

    logic [NUM_CHK-1:0] acc, acc_pass, acc_fail, drain_mask;
    logic [ID_W-1:0]    drain_id;
    logic               drain_hit, push, pop, ovf_set;

    assign acc      = chk_valid & ~chk_mask & {NUM_CHK{global_en & ~gate_rst}};
    assign acc_pass = acc & chk_pass;
    assign acc_fail = acc & ~chk_pass;

    // Fixed-priority pick of the lowest pending checker.
    always_comb begin
        drain_id  = '0;
        drain_hit = 1'b0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (pend[i]) begin
                drain_id  = ID_W'(i);
                drain_hit = 1'b1;
            end
        end
    end

    assign pop  = (cnt != '0) & rec_ready;
    assign push = drain_hit & ((cnt != (AW+1)'(FIFO_DEPTH)) | pop);

    always_comb begin
        drain_mask = '0;
        if (push) drain_mask[drain_id] = 1'b1;
    end

    // A second fail on a pending check is only a loss if that slot is not being freed now.
    assign ovf_set = |(acc_fail & pend & ~drain_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts       <= '0;
            pend     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            any_fail <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_CHK; i++) begin
                pass_q[i]  <= '0;
                fail_q[i]  <= '0;
                pend_ts[i] <= '0;
            end
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                mem_id[k] <= '0;
                mem_ts[k] <= '0;
            end
        end else begin
            ts <= ts + 1'b1;

            if (push) begin
                mem_id[wr_ptr] <= drain_id;
                mem_ts[wr_ptr] <= pend_ts[drain_id];
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;

            for (int i = 0; i < NUM_CHK; i++) begin
                if (acc_fail[i] && (!pend[i] || drain_mask[i])) begin
                    pend[i]    <= 1'b1;
                    pend_ts[i] <= ts;
                end else if (drain_mask[i]) begin
                    pend[i] <= 1'b0;
                end
            end

            if (clr_cnt) begin
                any_fail <= 1'b0;
                overflow <= 1'b0;
                for (int i = 0; i < NUM_CHK; i++) begin
                    pass_q[i] <= '0;
                    fail_q[i] <= '0;
                end
            end else begin
                if (|acc_fail) any_fail <= 1'b1;
                if (ovf_set)   overflow <= 1'b1;
                for (int i = 0; i < NUM_CHK; i++) begin
                    if (acc_pass[i] && pass_q[i] != '1) pass_q[i] <= pass_q[i] + 1'b1;
                    if (acc_fail[i] && fail_q[i] != '1) fail_q[i] <= fail_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CHK; g++) begin : g_pack
        assign pass_cnt[g*CNT_W +: CNT_W] = pass_q[g];
        assign fail_cnt[g*CNT_W +: CNT_W] = fail_q[g];
    end

    assign rec_valid = (cnt != '0);
    assign rec_id    = mem_id[rd_ptr];
    assign rec_ts    = mem_ts[rd_ptr];
endmodule
